// File: rtl/ascon_pkg.sv
// Shared constants, types and helpers for the single-block ASCON-128 engine.
package ascon_pkg;

  localparam int unsigned STATE_W = 320;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned DATA_W  = 40;
  localparam int unsigned LANE_W  = 64;

  localparam logic [LANE_W-1:0] ASCON_IV = 64'h80400c0600000000;

  // Last counter value of a 12-round and a 6-round pass, and the pb constant offset.
  localparam logic [3:0] PA_LAST   = 4'd11;
  localparam logic [3:0] PB_LAST   = 4'd5;
  localparam logic [3:0] PB_OFFSET = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD,
    ST_PT,
    ST_FINAL,
    ST_DONE
  } state_e;

  // Round constant table c[0..11].
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:    c = 8'hf0;
      4'd1:    c = 8'he1;
      4'd2:    c = 8'hd2;
      4'd3:    c = 8'hc3;
      4'd4:    c = 8'hb4;
      4'd5:    c = 8'ha5;
      4'd6:    c = 8'h96;
      4'd7:    c = 8'h87;
      4'd8:    c = 8'h78;
      4'd9:    c = 8'h69;
      4'd10:   c = 8'h5a;
      4'd11:   c = 8'h4b;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // 40-bit block padded out to one 64-bit rate lane.
  function automatic logic [LANE_W-1:0] pad_block(input logic [DATA_W-1:0] d);
    return {d, 8'h80, 16'h0000};
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant add, S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic [7:0]         rc_i,
  output logic [STATE_W-1:0] state_o
);

  logic [LANE_W-1:0] x0, x1, x2, x3, x4;
  logic [LANE_W-1:0] b0, b1, b2, b3, b4;
  logic [LANE_W-1:0] c0, c1, c2, c3, c4;
  logic [LANE_W-1:0] d0, d1, d2, d3, d4;
  logic [LANE_W-1:0] l0, l1, l2, l3, l4;

  assign x0 = state_i[319:256];
  assign x1 = state_i[255:192];
  assign x2 = state_i[191:128] ^ {56'h0, rc_i};
  assign x3 = state_i[127:64];
  assign x4 = state_i[63:0];

  // S-box input mixing
  assign b0 = x0 ^ x4;
  assign b1 = x1;
  assign b2 = x2 ^ x1;
  assign b3 = x3;
  assign b4 = x4 ^ x3;

  // chi core
  assign c0 = b0 ^ (~b1 & b2);
  assign c1 = b1 ^ (~b2 & b3);
  assign c2 = b2 ^ (~b3 & b4);
  assign c3 = b3 ^ (~b4 & b0);
  assign c4 = b4 ^ (~b0 & b1);

  // S-box output mixing
  assign d0 = c0 ^ c4;
  assign d1 = c1 ^ c0;
  assign d2 = ~c2;
  assign d3 = c3 ^ c2;
  assign d4 = c4;

  // Linear diffusion layer, rotations to the right
  assign l0 = d0 ^ {d0[18:0], d0[63:19]} ^ {d0[27:0], d0[63:28]};
  assign l1 = d1 ^ {d1[60:0], d1[63:61]} ^ {d1[38:0], d1[63:39]};
  assign l2 = d2 ^ {d2[0],    d2[63:1]}  ^ {d2[5:0],  d2[63:6]};
  assign l3 = d3 ^ {d3[9:0],  d3[63:10]} ^ {d3[16:0], d3[63:17]};
  assign l4 = d4 ^ {d4[6:0],  d4[63:7]}  ^ {d4[40:0], d4[63:41]};

  assign state_o = {l0, l1, l2, l3, l4};

endmodule

// File: rtl/ascon_encryption.sv
// Single-block ASCON-128 encryption: one round per cycle, 32-cycle latency.
module ascon_encryption
  import ascon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               encryption_start,
  input  logic [KEY_W-1:0]   key,
  input  logic [KEY_W-1:0]   nonce,
  input  logic [DATA_W-1:0]  ad,
  input  logic [DATA_W-1:0]  pt,
  output logic               encryption_fin,
  output logic [DATA_W-1:0]  ct,
  output logic [KEY_W-1:0]   tag,
  output logic [STATE_W-1:0] ini_stemp,
  output logic [STATE_W-1:0] ad_stemp,
  output logic [STATE_W-1:0] pt_stemp
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic               fin_q, fin_d;
  logic [DATA_W-1:0]  ct_q, ct_d;
  logic [KEY_W-1:0]   tag_q, tag_d;
  logic [STATE_W-1:0] ini_q, ini_d;
  logic [STATE_W-1:0] ads_q, ads_d;
  logic [STATE_W-1:0] pts_q, pts_d;

  logic [STATE_W-1:0] round_in;
  logic [STATE_W-1:0] round_out;
  logic [3:0]         rc_idx;
  logic [LANE_W-1:0]  x0_pt;

  // Absorb / key-XOR muxing in front of the round and constant selection
  always_comb begin
    round_in = s_q;
    if (state_q == ST_AD && cnt_q == 4'd0) begin
      round_in[319:256] = s_q[319:256] ^ pad_block(ad);
    end
    if (state_q == ST_FINAL && cnt_q == 4'd0) begin
      round_in[255:128] = s_q[255:128] ^ key;
    end
    rc_idx = (state_q == ST_AD) ? 4'(cnt_q + PB_OFFSET) : cnt_q;
  end

  ascon_round u_round (
    .state_i (round_in),
    .rc_i    (round_const(rc_idx)),
    .state_o (round_out)
  );

  assign x0_pt = s_q[319:256] ^ pad_block(pt);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (encryption_start) state_d = ST_INIT;
      ST_INIT:          if (cnt_q == PA_LAST) state_d = ST_AD;
      ST_AD:            if (cnt_q == PB_LAST) state_d = ST_PT;
      ST_PT:            state_d = ST_FINAL;
      ST_FINAL:         if (cnt_q == PA_LAST) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    cnt_d = cnt_q;
    s_d   = s_q;
    fin_d = fin_q;
    ct_d  = ct_q;
    tag_d = tag_q;
    ini_d = ini_q;
    ads_d = ads_q;
    pts_d = pts_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (encryption_start) begin
          s_d   = {ASCON_IV, key, nonce};
          cnt_d = 4'd0;
          fin_d = 1'b0;
        end
      end
      ST_INIT: begin
        s_d   = round_out;
        cnt_d = 4'(cnt_q + 4'd1);
        if (cnt_q == PA_LAST) begin
          s_d   = round_out ^ {{(STATE_W-KEY_W){1'b0}}, key};
          ini_d = s_d;
          cnt_d = 4'd0;
        end
      end
      ST_AD: begin
        s_d   = round_out;
        cnt_d = 4'(cnt_q + 4'd1);
        if (cnt_q == PB_LAST) begin
          s_d   = round_out ^ STATE_W'(1);
          ads_d = s_d;
          cnt_d = 4'd0;
        end
      end
      ST_PT: begin
        s_d   = {x0_pt, s_q[255:0]};
        ct_d  = x0_pt[63:24];
        pts_d = s_d;
        cnt_d = 4'd0;
      end
      ST_FINAL: begin
        s_d   = round_out;
        cnt_d = 4'(cnt_q + 4'd1);
        if (cnt_q == PA_LAST) begin
          tag_d = {round_out[127:64] ^ key[127:64], round_out[63:0] ^ key[63:0]};
          fin_d = 1'b1;
          cnt_d = 4'd0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
      s_q   <= '0;
      fin_q <= 1'b0;
      ct_q  <= '0;
      tag_q <= '0;
      ini_q <= '0;
      ads_q <= '0;
      pts_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      s_q   <= s_d;
      fin_q <= fin_d;
      ct_q  <= ct_d;
      tag_q <= tag_d;
      ini_q <= ini_d;
      ads_q <= ads_d;
      pts_q <= pts_d;
    end
  end

  assign encryption_fin = fin_q;
  assign ct             = ct_q;
  assign tag            = tag_q;
  assign ini_stemp      = ini_q;
  assign ad_stemp       = ads_q;
  assign pt_stemp       = pts_q;

endmodule

// File: tb/tb_ascon_encryption.sv
// Bench for ascon_encryption: table-driven S-box reference model feeding a scoreboard.
module tb_ascon_encryption;

  typedef struct packed {
    logic [39:0]  ct;
    logic [127:0] tag;
    logic [319:0] ini;
    logic [319:0] ads;
    logic [319:0] pts;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         encryption_start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] nonce = '0;
  logic [39:0]  ad = '0;
  logic [39:0]  pt = '0;
  logic         encryption_fin;
  logic [39:0]  ct;
  logic [127:0] tag;
  logic [319:0] ini_stemp, ad_stemp, pt_stemp;

  int pass_cnt = 0;
  int total    = 0;
  exp_t exp_q[$];

  localparam logic [127:0] GKEY   = 128'hb7234a4db9fb8b7c2aa5735ebef1180c;
  localparam logic [127:0] GNONCE = 128'h8ebb295da81c74b58306d4e8362e2242;
  localparam logic [39:0]  GAD    = 40'h4153434f4e;
  localparam logic [39:0]  GPT    = 40'h6173636f6e;

  ascon_encryption dut (
    .clk              (clk),
    .rst              (rst),
    .encryption_start (encryption_start),
    .key              (key),
    .nonce            (nonce),
    .ad               (ad),
    .pt               (pt),
    .encryption_fin   (encryption_fin),
    .ct               (ct),
    .tag              (tag),
    .ini_stemp        (ini_stemp),
    .ad_stemp         (ad_stemp),
    .pt_stemp         (pt_stemp)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox(input logic [4:0] v);
    logic [255:0] tab;
    int idx;
    tab = 256'h040b1f141a1509021b0508121d03061c1e13070e000d1118100c0119160a0f17;
    idx = (31 - int'(v)) * 8;
    return tab[idx +: 5];
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] rnd(input logic [319:0] s, input int r);
    logic [63:0] x[5];
    logic [63:0] y[5];
    logic [4:0]  o;
    for (int j = 0; j < 5; j++) x[j] = s[319 - 64*j -: 64];
    x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
    for (int i = 0; i < 64; i++) begin
      o = sbox({x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]});
      for (int j = 0; j < 5; j++) y[j][i] = o[4 - j];
    end
    y[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
    y[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
    y[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
    y[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
    y[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic exp_t model(input logic [127:0] k, input logic [127:0] n,
                                 input logic [39:0] a, input logic [39:0] p);
    exp_t e;
    logic [319:0] s;
    s = {64'h80400c0600000000, k, n};
    for (int r = 0; r < 12; r++) s = rnd(s, r);
    s[127:0] = s[127:0] ^ k;
    e.ini = s;
    s[319:256] = s[319:256] ^ {a, 8'h80, 16'h0};
    for (int r = 6; r < 12; r++) s = rnd(s, r);
    s[0] = ~s[0];
    e.ads = s;
    s[319:256] = s[319:256] ^ {p, 8'h80, 16'h0};
    e.ct  = s[319:280];
    e.pts = s;
    s[255:128] = s[255:128] ^ k;
    for (int r = 0; r < 12; r++) s = rnd(s, r);
    e.tag = s[127:0] ^ k;
    return e;
  endfunction

  // ---------------- driver ----------------
  // Starts a run, optionally re-pulses start at busy_at or resets at abort_at,
  // returns the edge count at which encryption_fin rose (0 on timeout).
  task automatic do_run(input logic [127:0] k, input logic [127:0] n,
                        input logic [39:0] a, input logic [39:0] p,
                        input int busy_at, input int abort_at,
                        output int edges, output logic fin1, output exp_t e);
    exp_q.push_back(model(k, n, a, p));
    key = k; nonce = n; ad = a; pt = p;
    encryption_start = 1'b1;
    edges = 0;
    fin1 = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        encryption_start = 1'b0;
        fin1 = encryption_fin;
      end
      if (busy_at != 0 && c == busy_at - 1) encryption_start = 1'b1;
      if (busy_at != 0 && c == busy_at)     encryption_start = 1'b0;
      if (abort_at != 0 && c == abort_at) begin
        rst = 1'b0;
        #1;
        edges = c;
        break;
      end
      if (encryption_fin === 1'b1) begin
        edges = c;
        break;
      end
    end
    e = exp_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (encryption_fin !== 1'b0) $display("FAIL reset_fin got %b exp 0", encryption_fin); else pass_cnt++;
    total++; if (ct !== '0) $display("FAIL reset_ct got %h exp 0", ct); else pass_cnt++;
    total++; if (tag !== '0) $display("FAIL reset_tag got %h exp 0", tag); else pass_cnt++;
    total++; if (ini_stemp !== '0) $display("FAIL reset_ini got %h exp 0", ini_stemp); else pass_cnt++;
    total++; if (ad_stemp !== '0) $display("FAIL reset_ad got %h exp 0", ad_stemp); else pass_cnt++;
    total++; if (pt_stemp !== '0) $display("FAIL reset_pt got %h exp 0", pt_stemp); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_golden();
    int edges; logic f1; exp_t e;
    do_run(GKEY, GNONCE, GAD, GPT, 0, 0, edges, f1, e);
    total++; if (edges != 32) $display("FAIL golden_latency got %0d exp 32", edges); else pass_cnt++;
    total++; if (ct !== e.ct) $display("FAIL golden_ct got %h exp %h", ct, e.ct); else pass_cnt++;
    total++; if (tag !== e.tag) $display("FAIL golden_tag got %h exp %h", tag, e.tag); else pass_cnt++;
    total++; if (ini_stemp !== e.ini) $display("FAIL golden_ini got %h exp %h", ini_stemp, e.ini); else pass_cnt++;
    total++; if (ad_stemp !== e.ads) $display("FAIL golden_ad got %h exp %h", ad_stemp, e.ads); else pass_cnt++;
    total++; if (pt_stemp !== e.pts) $display("FAIL golden_pt got %h exp %h", pt_stemp, e.pts); else pass_cnt++;
  endtask

  task automatic test_keystream();
    int edges; logic f1; exp_t e;
    logic [39:0] ct1; logic [127:0] tag1; logic [319:0] ad1;
    do_run(GKEY, GNONCE, GAD, 40'h0, 0, 0, edges, f1, e);
    total++; if (ct !== e.ct) $display("FAIL ks_ct0 got %h exp %h", ct, e.ct); else pass_cnt++;
    ct1 = ct; tag1 = tag; ad1 = ad_stemp;
    do_run(GKEY, GNONCE, GAD, 40'hffffffffff, 0, 0, edges, f1, e);
    total++; if (ct !== e.ct) $display("FAIL ks_ct1 got %h exp %h", ct, e.ct); else pass_cnt++;
    total++; if ((ct ^ ct1) !== 40'hffffffffff) $display("FAIL ks_xor got %h exp ffffffffff", ct ^ ct1); else pass_cnt++;
    total++; if (ad_stemp !== ad1) $display("FAIL ks_ad_same got %h exp %h", ad_stemp, ad1); else pass_cnt++;
    total++; if (tag === tag1) $display("FAIL ks_tag_differs got %h exp not %h", tag, tag1); else pass_cnt++;
  endtask

  task automatic test_ad_isolation();
    int edges; logic f1; exp_t e;
    logic [319:0] ini1, ad1;
    do_run(GKEY, GNONCE, 40'h0102030405, GPT, 0, 0, edges, f1, e);
    ini1 = ini_stemp; ad1 = ad_stemp;
    do_run(GKEY, GNONCE, 40'h0102030406, GPT, 0, 0, edges, f1, e);
    total++; if (ini_stemp !== ini1) $display("FAIL adiso_ini_same got %h exp %h", ini_stemp, ini1); else pass_cnt++;
    total++; if (ad_stemp === ad1) $display("FAIL adiso_ad_differs got %h exp not %h", ad_stemp, ad1); else pass_cnt++;
    total++; if (ad_stemp !== e.ads) $display("FAIL adiso_ad got %h exp %h", ad_stemp, e.ads); else pass_cnt++;
  endtask

  task automatic test_busy_start();
    int edges; logic f1; exp_t e;
    do_run(GKEY ^ 128'h1, GNONCE, GAD, GPT, 10, 0, edges, f1, e);
    total++; if (edges != 32) $display("FAIL busy_latency got %0d exp 32", edges); else pass_cnt++;
    total++; if (ct !== e.ct) $display("FAIL busy_ct got %h exp %h", ct, e.ct); else pass_cnt++;
    total++; if (tag !== e.tag) $display("FAIL busy_tag got %h exp %h", tag, e.tag); else pass_cnt++;
  endtask

  task automatic test_start_in_done();
    int edges; logic f1; exp_t e;
    total++; if (encryption_fin !== 1'b1) $display("FAIL done_level got %b exp 1", encryption_fin); else pass_cnt++;
    do_run(GKEY, ~GNONCE, GPT, GAD, 0, 0, edges, f1, e);
    total++; if (f1 !== 1'b0) $display("FAIL done_fin_drop got %b exp 0", f1); else pass_cnt++;
    total++; if (edges != 32) $display("FAIL done_latency got %0d exp 32", edges); else pass_cnt++;
    total++; if (tag !== e.tag) $display("FAIL done_tag got %h exp %h", tag, e.tag); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int edges; logic f1; exp_t e;
    logic [319:0] ini1;
    do_run(GKEY, 128'h0, GAD, GPT, 0, 0, edges, f1, e);
    total++; if (ini_stemp !== e.ini) $display("FAIL b2b_ini0 got %h exp %h", ini_stemp, e.ini); else pass_cnt++;
    total++; if (tag !== e.tag) $display("FAIL b2b_tag0 got %h exp %h", tag, e.tag); else pass_cnt++;
    ini1 = ini_stemp;
    do_run(GKEY, 128'h1, GAD, GPT, 0, 0, edges, f1, e);
    total++; if (ini_stemp !== e.ini) $display("FAIL b2b_ini1 got %h exp %h", ini_stemp, e.ini); else pass_cnt++;
    total++; if (ct !== e.ct) $display("FAIL b2b_ct1 got %h exp %h", ct, e.ct); else pass_cnt++;
    total++; if (tag !== e.tag) $display("FAIL b2b_tag1 got %h exp %h", tag, e.tag); else pass_cnt++;
    total++; if (ini_stemp === ini1) $display("FAIL b2b_ini_differs got %h exp not %h", ini_stemp, ini1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int edges; logic f1; exp_t e;
    do_run(GKEY, GNONCE, GAD, GPT, 0, 25, edges, f1, e);
    total++; if (encryption_fin !== 1'b0) $display("FAIL abort_fin got %b exp 0", encryption_fin); else pass_cnt++;
    total++; if (ct !== '0) $display("FAIL abort_ct got %h exp 0", ct); else pass_cnt++;
    total++; if (tag !== '0) $display("FAIL abort_tag got %h exp 0", tag); else pass_cnt++;
    total++; if (ini_stemp !== '0) $display("FAIL abort_ini got %h exp 0", ini_stemp); else pass_cnt++;
    total++; if (ad_stemp !== '0) $display("FAIL abort_ad got %h exp 0", ad_stemp); else pass_cnt++;
    total++; if (pt_stemp !== '0) $display("FAIL abort_pt got %h exp 0", pt_stemp); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_run(GKEY, GNONCE, GAD, GPT, 0, 0, edges, f1, e);
    total++; if (edges != 32) $display("FAIL recover_latency got %0d exp 32", edges); else pass_cnt++;
    total++; if (tag !== e.tag) $display("FAIL recover_tag got %h exp %h", tag, e.tag); else pass_cnt++;
    total++; if (pt_stemp !== e.pts) $display("FAIL recover_pt got %h exp %h", pt_stemp, e.pts); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_golden();
    test_keystream();
    test_ad_isolation();
    test_busy_start();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ascon_encryption.md
# ascon_encryption

Single-block ASCON-128 authenticated-encryption engine. It accepts a 128-bit key, a 128-bit nonce, exactly 40 bits of associated data and exactly 40 bits of plaintext, and produces a 40-bit ciphertext and a 128-bit tag. It is a standalone crypto core driven by a start pulse, with a done flag. It also exposes three intermediate 320-bit state snapshots for debug and verification.

## Interface
- No parameters. IV, round constants and rates are fixed constants (see Structure).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-low.
- encryption_start  in  1  start pulse; sampled only in IDLE or DONE.
- key  in  128  K; must be held stable from start until encryption_fin.
- nonce  in  128  N; sampled at start.
- ad  in  40  associated data A.
- pt  in  40  plaintext P.
- encryption_fin  out  1  high from completion until the next start or reset.
- ct  out  40  ciphertext C.
- tag  out  128  tag T.
- ini_stemp  out  320  state after initialization.
- ad_stemp  out  320  state after AD processing.
- pt_stemp  out  320  state after plaintext absorb.

## Operation
- State S = x0‖x1‖x2‖x3‖x4, with x0 in bits 319:256. Rate is x0. IV = 64'h80400c0600000000.
- One permutation round per cycle. Each round does three steps:
  - Constant addition: x2 ^= c.
  - 5-bit bitsliced S-box, ASCON χ-based.
  - Linear layer, rotations right:
    - x0: 19/28
    - x1: 61/39
    - x2: 1/6
    - x3: 10/17
    - x4: 7/41
- Constants c[0..11] = f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b.
  - pᵃ uses rounds 0–11.
  - pᵇ uses rounds 6–11.
- Padding: A1 = {ad, 8'h80, 16'h0}. P1 = {pt, 8'h80, 16'h0}.
- FSM states and transitions:
  - **IDLE**: on start, S ← IV‖K‖N, round counter ← 0, encryption_fin ← 0; go INIT.
  - **INIT**: apply round per cycle for 12 cycles. The 12th update is S ← pᵃ(S) ^ (0¹⁹²‖K); latch ini_stemp with the same value. Go AD.
  - **AD**: 6 rounds. The first round's input has x0 ^= A1. The 6th update also XORs 1 into bit 0 of x4 (domain separation). Latch ad_stemp. Go PT.
  - **PT**: one cycle, no round. Updates:
    - x0 ← x0 ^ P1
    - ct ← new x0[63:24]
    - pt_stemp ← new S
    - Go FINAL.
  - **FINAL**: 12 rounds. The first round's input has x1 ^= K[127:64] and x2 ^= K[63:0]. On the 12th round:
    - tag ← (x3' ^ K[127:64]) ‖ (x4' ^ K[63:0])
    - encryption_fin ← 1
    - Go DONE.
  - **DONE**: hold all outputs. A start here behaves as in IDLE and clears encryption_fin.
- Start in INIT, AD, PT or FINAL is ignored.

## Timing
- Reset (async): FSM → IDLE; counters, S, ct, tag and all stemp outputs → 0; encryption_fin → 0.
- Reset mid-operation aborts immediately. There is no partial output.
- Latency: encryption_fin rises on the 32nd rising edge, counting the edge that samples start as edge 1.
  - Breakdown: 1 load + 12 INIT + 6 AD + 1 PT + 12 FINAL.
- Snapshot outputs and ct update only at the edges named above. Otherwise they hold.
- encryption_fin is a level, not a pulse.

## Structure
- Package ascon_pkg holds:
  - IV
  - round-constant table
  - FSM state enum
  - width localparams: 320, 128, 40, 64
- Sub-module ascon_round: purely combinational, one round. Inputs: 320-bit state and 8-bit constant. Output: 320-bit state.
- Top level holds:
  - FSM
  - 4-bit round counter
  - state register
  - absorb/key-XOR muxes in front of ascon_round
  - output registers

## Test plan
- Reset: assert rst=0 mid-FINAL → all outputs 0 and encryption_fin=0 immediately. After release, a new start completes normally.
- Golden vector: key b7234a4db9fb8b7c2aa5735ebef1180c, nonce 8ebb295da81c74b58306d4e8362e2242, ad 4153434f4e, pt 6173636f6e.
  - ct, tag, ini_stemp, ad_stemp and pt_stemp must match a software ASCON-128 model bit-exactly.
  - encryption_fin must rise exactly 32 edges after start.
- Keystream property: same key/nonce/ad with pt=0000000000 and then pt=ffffffffff → ct₁ ^ ct₂ = ffffffffff, ad_stemp identical, tag differs.
- AD isolation: change ad only → ini_stemp identical, ad_stemp differs.
- Start while busy: pulse start at edge 10 → ignored, completion still at edge 32. Start in DONE → encryption_fin drops the next cycle and the run restarts.
- Back-to-back: two runs with different nonces → ini_stemp differs and each output matches the model.
